// File: rtl/fft_stream_core.sv
// Sequential radix-2 DIT FFT/IFFT engine: bit-reversed frame load, in-place
// butterflies one per cycle, natural-order unload over valid/ready.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_LOAD    | accept samples, sample n written to address bitrev(n)
// ST_COMPUTE | one butterfly per cycle, LOG2N stages of N/2 butterflies
// ST_UNLOAD  | present bins k = 0..N-1, advance on out_ready
module fft_stream_core #(
   parameter int DW    = 12,
   parameter int LOG2N = 3,
   parameter int TW    = 10
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic signed [DW-1:0] in_r,
   input  logic signed [DW-1:0] in_i,
   input  logic                 in_inv,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic signed [DW-1:0] out_r,
   output logic signed [DW-1:0] out_i,
   output logic                 out_last,
   output logic                 busy
);
   localparam int N  = 1 << LOG2N;
   localparam int HW = LOG2N - 1;
   localparam int PW = DW + TW;
   localparam int SW = DW + TW + 2;
   localparam logic [LOG2N-1:0] N_LAST = LOG2N'(N - 1);
   localparam logic [LOG2N-1:0] ONE_N  = LOG2N'(1);
   localparam logic [HW-1:0]    ONE_H  = HW'(1);
   localparam logic [2:0]       STAGE_LAST = 3'(LOG2N - 1);

   typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_UNLOAD} state_t;

   state_t               state_q, state_d;
   logic [LOG2N-1:0]     n_q, n_d, k_q, k_d;
   logic [2:0]           stage_q, stage_d;
   logic [HW-1:0]        bfly_q, bfly_d;
   logic                 inv_q, inv_d;
   logic signed [DW-1:0] mem_r_q [N];
   logic signed [DW-1:0] mem_r_d [N];
   logic signed [DW-1:0] mem_i_q [N];
   logic signed [DW-1:0] mem_i_d [N];

   logic                 in_hs, out_hs, bfly_last, stage_last;
   logic [LOG2N-1:0]     bf_j, bf_half, bf_lo, bf_a, bf_b;
   logic [4:0]           tw_idx;
   logic signed [TW-1:0] tw_cos, tw_sin, w_r, w_i;
   logic signed [DW-1:0] a_r, a_i, b_r, b_i, res_ar, res_ai, res_br, res_bi;
   logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
   logic signed [SW-1:0] t_r, t_i, sum_r, sum_i, dif_r, dif_i;

   function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
      logic [LOG2N-1:0] r;
      for (int i = 0; i < LOG2N; i++) r[i] = v[LOG2N-1-i];
      return r;
   endfunction

   // First quadrant of round(256*cos(2*pi*m/64)); the rest is folded from it.
   function automatic logic signed [TW-1:0] qcos(input logic [4:0] m);
      logic signed [TW-1:0] v;
      case (m)
         5'd0:    v = TW'(256);
         5'd1:    v = TW'(255);
         5'd2:    v = TW'(251);
         5'd3:    v = TW'(245);
         5'd4:    v = TW'(237);
         5'd5:    v = TW'(226);
         5'd6:    v = TW'(213);
         5'd7:    v = TW'(198);
         5'd8:    v = TW'(181);
         5'd9:    v = TW'(162);
         5'd10:   v = TW'(142);
         5'd11:   v = TW'(121);
         5'd12:   v = TW'(98);
         5'd13:   v = TW'(74);
         5'd14:   v = TW'(50);
         5'd15:   v = TW'(25);
         default: v = TW'(0);
      endcase
      return v;
   endfunction

   assign in_hs      = in_valid && (state_q == ST_LOAD);
   assign out_hs     = out_ready && (state_q == ST_UNLOAD);
   assign bfly_last  = (bfly_q == '1);
   assign stage_last = (stage_q == STAGE_LAST);

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_LOAD;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD:    if (in_hs && n_q == N_LAST) state_d = ST_COMPUTE;
         ST_COMPUTE: if (bfly_last && stage_last) state_d = ST_UNLOAD;
         ST_UNLOAD:  if (out_hs && k_q == N_LAST) state_d = ST_LOAD;
         default:    state_d = ST_LOAD;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == ST_LOAD);
      out_valid = (state_q == ST_UNLOAD);
      busy      = (state_q == ST_COMPUTE) || (state_q == ST_UNLOAD);
      out_r     = '0;
      out_i     = '0;
      out_last  = 1'b0;
      if (state_q == ST_UNLOAD) begin
         out_r    = mem_r_q[k_q];
         out_i    = mem_i_q[k_q];
         out_last = (k_q == N_LAST);
      end
   end

   // Pair (a, a + 2^s) for butterfly j of stage s; twiddle index p * 2^(5-s).
   always_comb begin
      bf_j    = LOG2N'(bfly_q);
      bf_half = ONE_N << stage_q;
      bf_lo   = bf_j & (bf_half - ONE_N);
      bf_a    = ((bf_j >> stage_q) << (stage_q + 3'd1)) | bf_lo;
      bf_b    = bf_a | bf_half;
      tw_idx  = 5'(bf_lo) << (3'd5 - stage_q);
   end

   always_comb begin
      if (tw_idx <= 5'd16) begin
         tw_cos = qcos(tw_idx);
         tw_sin = qcos(5'd16 - tw_idx);
      end else begin
         tw_cos = -qcos(5'(6'd32 - {1'b0, tw_idx}));
         tw_sin = qcos(tw_idx - 5'd16);
      end
      w_r = tw_cos;
      w_i = inv_q ? tw_sin : -tw_sin;
   end

   // Sums are kept at full precision so the inverse halving sees no wrap.
   always_comb begin
      a_r   = mem_r_q[bf_a];
      a_i   = mem_i_q[bf_a];
      b_r   = mem_r_q[bf_b];
      b_i   = mem_i_q[bf_b];
      p_rr  = PW'(b_r) * PW'(w_r);
      p_ii  = PW'(b_i) * PW'(w_i);
      p_ri  = PW'(b_i) * PW'(w_r);
      p_ir  = PW'(b_r) * PW'(w_i);
      t_r   = SW'(p_rr >>> 8) - SW'(p_ii >>> 8);
      t_i   = SW'(p_ri >>> 8) + SW'(p_ir >>> 8);
      sum_r = SW'(a_r) + t_r;
      sum_i = SW'(a_i) + t_i;
      dif_r = SW'(a_r) - t_r;
      dif_i = SW'(a_i) - t_i;
      if (inv_q) begin
         sum_r = sum_r >>> 1;
         sum_i = sum_i >>> 1;
         dif_r = dif_r >>> 1;
         dif_i = dif_i >>> 1;
      end
      res_ar = DW'(sum_r);
      res_ai = DW'(sum_i);
      res_br = DW'(dif_r);
      res_bi = DW'(dif_i);
   end

   always_comb begin
      mem_r_d = mem_r_q;
      mem_i_d = mem_i_q;
      if (in_hs) begin
         mem_r_d[bitrev(n_q)] = in_r;
         mem_i_d[bitrev(n_q)] = in_i;
      end
      if (state_q == ST_COMPUTE) begin
         mem_r_d[bf_a] = res_ar;
         mem_i_d[bf_a] = res_ai;
         mem_r_d[bf_b] = res_br;
         mem_i_d[bf_b] = res_bi;
      end
   end

   always_comb begin
      n_d     = n_q;
      k_d     = k_q;
      stage_d = stage_q;
      bfly_d  = bfly_q;
      inv_d   = inv_q;
      if (in_hs) begin
         n_d = n_q + ONE_N;
         if (n_q == '0) inv_d = in_inv;
      end
      if (state_q == ST_COMPUTE) begin
         bfly_d = bfly_q + ONE_H;
         if (bfly_last) stage_d = stage_last ? 3'd0 : stage_q + 3'd1;
      end
      if (out_hs) k_d = k_q + ONE_N;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n_q     <= '0;
         k_q     <= '0;
         stage_q <= '0;
         bfly_q  <= '0;
         inv_q   <= 1'b0;
      end else begin
         n_q     <= n_d;
         k_q     <= k_d;
         stage_q <= stage_d;
         bfly_q  <= bfly_d;
         inv_q   <= inv_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_r_q <= mem_r_d;
      mem_i_q <= mem_i_d;
   end
endmodule

// File: tb/tb_fft_stream_core.sv
// Bench for fft_stream_core: an N=8 (DW=12) and an N=64 (DW=14) instance
// checked against an integer FFT model with trig-derived twiddles.
module tb_fft_stream_core;
   localparam int TW = 10;

   logic clk;
   logic rst [2];
   logic in_valid [2];
   logic in_ready [2];
   logic in_inv [2];
   logic out_valid [2];
   logic out_ready [2];
   logic out_last [2];
   logic busy [2];
   logic signed [15:0] in_r [2];
   logic signed [15:0] in_i [2];
   logic signed [11:0] out_r0, out_i0;
   logic signed [13:0] out_r1, out_i1;
   logic signed [15:0] o_r [2];
   logic signed [15:0] o_i [2];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int exp_r [2][64];
   int exp_i [2][64];
   int cap_r [2][64];
   int cap_i [2][64];
   int exp_frames [2];
   int done_frames [2];
   int rd_idx [2];
   int rise_cyc [2];
   int acc_cyc [2];
   int busy_cnt [2];
   bit bp [2];

   assign o_r[0] = 16'(out_r0);
   assign o_i[0] = 16'(out_i0);
   assign o_r[1] = 16'(out_r1);
   assign o_i[1] = 16'(out_i1);

   fft_stream_core #(.DW(12), .LOG2N(3), .TW(TW)) u_dut8 (
      .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_r(in_r[0][11:0]), .in_i(in_i[0][11:0]), .in_inv(in_inv[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_r(out_r0),
      .out_i(out_i0), .out_last(out_last[0]), .busy(busy[0]));

   fft_stream_core #(.DW(14), .LOG2N(6), .TW(TW)) u_dut64 (
      .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_r(in_r[1][13:0]), .in_i(in_i[1][13:0]), .in_inv(in_inv[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_r(out_r1),
      .out_i(out_i1), .out_last(out_last[1]), .busy(busy[1]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
      $fatal(1, "watchdog");
   end

   function automatic int nn(int d);
      return (d != 0) ? 64 : 8;
   endfunction

   function automatic int dwof(int d);
      return (d != 0) ? 14 : 12;
   endfunction

   task automatic check(string name, int act, int expv);
      tests++;
      if (act != expv) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   function automatic int wrap(int v, int dw);
      int m;
      m = v & ((1 << dw) - 1);
      if (m >= (1 << (dw - 1))) m -= (1 << dw);
      return m;
   endfunction

   function automatic int rnd(real x);
      return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
   endfunction

   // Textbook in-place DIT FFT on integers with the core's fixed-point rules.
   function automatic void model(input int xr[64], input int xi[64], input int n,
                                 input bit inv, input int dw,
                                 output int yr[64], output int yi[64]);
      int lg;
      lg = 0;
      while ((1 << lg) < n) lg++;
      for (int i = 0; i < 64; i++) begin
         yr[i] = 0;
         yi[i] = 0;
      end
      for (int i = 0; i < n; i++) begin
         int r;
         r = 0;
         for (int b = 0; b < lg; b++) r |= ((i >> b) & 1) << (lg - 1 - b);
         yr[r] = xr[i];
         yi[r] = xi[i];
      end
      for (int s = 0; s < lg; s++) begin
         int h;
         h = 1 << s;
         for (int g = 0; g < n; g += 2 * h) begin
            for (int p = 0; p < h; p++) begin
               real th;
               int wr, wi, a, b, tr, ti, sr, si, dr, di;
               th = 2.0 * 3.14159265358979 * p / (2 * h);
               wr = rnd(256.0 * $cos(th));
               wi = rnd(256.0 * $sin(th));
               if (!inv) wi = -wi;
               a  = g + p;
               b  = a + h;
               tr = ((wr * yr[b]) >>> 8) - ((wi * yi[b]) >>> 8);
               ti = ((wr * yi[b]) >>> 8) + ((wi * yr[b]) >>> 8);
               sr = yr[a] + tr;
               si = yi[a] + ti;
               dr = yr[a] - tr;
               di = yi[a] - ti;
               if (inv) begin
                  sr = sr >>> 1;
                  si = si >>> 1;
                  dr = dr >>> 1;
                  di = di >>> 1;
               end
               yr[a] = wrap(sr, dw);
               yi[a] = wrap(si, dw);
               yr[b] = wrap(dr, dw);
               yi[b] = wrap(di, dw);
            end
         end
      end
   endfunction

   initial begin
      out_ready[0] = 1'b1;
      out_ready[1] = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         for (int d = 0; d < 2; d++) out_ready[d] = bp[d] ? !out_ready[d] : 1'b1;
      end
   end

   // Single compare process: every valid output against the model frame.
   initial begin
      int pr [2];
      int pi [2];
      int pl [2];
      bit hold [2];
      bit pv [2];
      for (int d = 0; d < 2; d++) begin
         hold[d] = 0;
         pv[d] = 0;
         rd_idx[d] = 0;
         done_frames[d] = 0;
         busy_cnt[d] = 0;
      end
      forever begin
         @(negedge clk);
         for (int d = 0; d < 2; d++) begin
            if (busy[d]) busy_cnt[d]++;
            if (out_valid[d] && !pv[d]) rise_cyc[d] = cyc;
            if (hold[d]) begin
               check($sformatf("d%0d hold valid", d), int'(out_valid[d]), 1);
               check($sformatf("d%0d hold re", d), int'(o_r[d]), pr[d]);
               check($sformatf("d%0d hold im", d), int'(o_i[d]), pi[d]);
               check($sformatf("d%0d hold last", d), int'(out_last[d]), pl[d]);
            end
            if (out_valid[d]) begin
               if (exp_frames[d] == done_frames[d]) begin
                  check($sformatf("d%0d spurious out_valid", d), int'(out_valid[d]), 0);
               end else begin
                  check($sformatf("d%0d bin%0d re", d, rd_idx[d]), int'(o_r[d]), exp_r[d][rd_idx[d]]);
                  check($sformatf("d%0d bin%0d im", d, rd_idx[d]), int'(o_i[d]), exp_i[d][rd_idx[d]]);
                  check($sformatf("d%0d bin%0d last", d, rd_idx[d]), int'(out_last[d]),
                        (rd_idx[d] == nn(d) - 1) ? 1 : 0);
                  if (out_ready[d]) begin
                     cap_r[d][rd_idx[d]] = int'(o_r[d]);
                     cap_i[d][rd_idx[d]] = int'(o_i[d]);
                     rd_idx[d]++;
                     if (rd_idx[d] == nn(d)) begin
                        rd_idx[d] = 0;
                        done_frames[d]++;
                     end
                  end
               end
            end
            hold[d] = out_valid[d] && !out_ready[d];
            pr[d] = int'(o_r[d]);
            pi[d] = int'(o_i[d]);
            pl[d] = int'(out_last[d]);
            pv[d] = out_valid[d];
         end
      end
   end

   // Called right after a posedge (+1). in_inv is inverted after the first
   // sample so every frame also exercises the mode latch.
   task automatic run_frame(input int d, input int xr[64], input int xi[64],
                            input bit inv, input bit gaps, input bit expect_out);
      int n, i, budget;
      int yr[64], yi[64];
      n = nn(d);
      if (expect_out) begin
         model(xr, xi, n, inv, dwof(d), yr, yi);
         for (int k = 0; k < 64; k++) begin
            exp_r[d][k] = yr[k];
            exp_i[d][k] = yi[k];
         end
         exp_frames[d]++;
      end
      i = 0;
      budget = 10 * n + 50;
      while (i < n && budget > 0) begin
         in_valid[d] = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
         in_r[d] = 16'(xr[i]);
         in_i[d] = 16'(xi[i]);
         in_inv[d] = (i == 0) ? inv : !inv;
         @(negedge clk);
         if (in_valid[d] && in_ready[d]) begin
            if (i == n - 1) acc_cyc[d] = cyc;
            i++;
         end
         @(posedge clk);
         #1;
         budget--;
      end
      in_valid[d] = 1'b0;
      check($sformatf("d%0d samples accepted", d), i, n);
   endtask

   task automatic wait_drain(input int d);
      int budget;
      budget = 2000;
      while (exp_frames[d] != done_frames[d] && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
      end
      check($sformatf("d%0d frames drained", d), done_frames[d], exp_frames[d]);
   endtask

   task automatic rand_frame(input int d, input bit inv, input bit gaps);
      int xr[64], xi[64];
      int h;
      h = 1 << (dwof(d) - 1);
      for (int k = 0; k < 64; k++) begin
         xr[k] = int'($urandom_range(0, 2 * h - 1)) - h;
         xi[k] = int'($urandom_range(0, 2 * h - 1)) - h;
      end
      run_frame(d, xr, xi, inv, gaps, 1'b1);
      wait_drain(d);
   endtask

   initial begin
      int xr[64], xi[64], yr[64], yi[64];
      int sv_r[64], sv_i[64];
      int b0, bad;
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1;
         in_valid[d] = 1'b0;
         in_inv[d] = 1'b0;
         in_r[d] = '0;
         in_i[d] = '0;
         exp_frames[d] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("d%0d reset in_ready", d), int'(in_ready[d]), 1);
         check($sformatf("d%0d reset out_valid", d), int'(out_valid[d]), 0);
         check($sformatf("d%0d reset out_r", d), int'(o_r[d]), 0);
         check($sformatf("d%0d reset out_i", d), int'(o_i[d]), 0);
         check($sformatf("d%0d reset out_last", d), int'(out_last[d]), 0);
         check($sformatf("d%0d reset busy", d), int'(busy[d]), 0);
      end
      @(posedge clk);
      #1;

      // Hand-computed values that pin the model.
      for (int k = 0; k < 64; k++) begin xr[k] = (k == 0) ? 80 : 0; xi[k] = 0; end
      model(xr, xi, 8, 1'b1, 12, yr, yi);
      check("model dc inverse x[5]", yr[5], 10);
      for (int k = 0; k < 64; k++) begin xr[k] = 10; xi[k] = 0; end
      model(xr, xi, 8, 1'b0, 12, yr, yi);
      check("model dc forward X[0]", yr[0], 80);
      check("model dc forward X[3]", yr[3], 0);

      // Impulse, forward, N=8.
      for (int k = 0; k < 64; k++) begin xr[k] = (k == 0) ? 64 : 0; xi[k] = 0; end
      b0 = busy_cnt[0];
      run_frame(0, xr, xi, 1'b0, 1'b0, 1'b1);
      wait_drain(0);
      check("impulse busy cycles", busy_cnt[0] - b0, 20);
      check("impulse latency", rise_cyc[0] - acc_cyc[0], 13);
      for (int k = 0; k < 8; k++) begin
         check($sformatf("impulse bin%0d re", k), cap_r[0][k], 64);
         check($sformatf("impulse bin%0d im", k), cap_i[0][k], 0);
      end

      // DC inverse, then DC forward.
      for (int k = 0; k < 64; k++) begin xr[k] = (k == 0) ? 80 : 0; xi[k] = 0; end
      run_frame(0, xr, xi, 1'b1, 1'b0, 1'b1);
      wait_drain(0);
      for (int k = 0; k < 8; k++) check($sformatf("dc inverse x%0d re", k), cap_r[0][k], 10);
      for (int k = 0; k < 64; k++) begin xr[k] = 10; xi[k] = 0; end
      run_frame(0, xr, xi, 1'b0, 1'b0, 1'b1);
      wait_drain(0);
      for (int k = 0; k < 8; k++)
         check($sformatf("dc forward X%0d re", k), cap_r[0][k], (k == 0) ? 80 : 0);

      // Alternating, N=64, forward.
      for (int k = 0; k < 64; k++) begin xr[k] = (k % 2 == 0) ? 32 : -32; xi[k] = 0; end
      run_frame(1, xr, xi, 1'b0, 1'b0, 1'b1);
      wait_drain(1);
      check("alternating latency", rise_cyc[1] - acc_cyc[1], 193);
      bad = 0;
      for (int k = 0; k < 64; k++) begin
         int er;
         er = (k == 32) ? cap_r[1][k] - 2048 : cap_r[1][k];
         if (er > 2 || er < -2 || cap_i[1][k] > 2 || cap_i[1][k] < -2) bad++;
      end
      check("alternating bins out of tolerance", bad, 0);

      // Random frames, both modes, both sizes.
      for (int r = 0; r < 6; r++) rand_frame(0, r[0], 1'b0);
      for (int r = 0; r < 3; r++) rand_frame(1, r[0], 1'b0);

      // Backpressure: same frame stalled and unstalled must agree.
      for (int k = 0; k < 64; k++) begin
         xr[k] = int'($urandom_range(0, 1023)) - 512;
         xi[k] = int'($urandom_range(0, 1023)) - 512;
      end
      run_frame(0, xr, xi, 1'b0, 1'b0, 1'b1);
      wait_drain(0);
      for (int k = 0; k < 8; k++) begin sv_r[k] = cap_r[0][k]; sv_i[k] = cap_i[0][k]; end
      bp[0] = 1'b1;
      run_frame(0, xr, xi, 1'b0, 1'b1, 1'b1);
      wait_drain(0);
      bad = 0;
      for (int k = 0; k < 8; k++) if (sv_r[k] != cap_r[0][k] || sv_i[k] != cap_i[0][k]) bad++;
      check("backpressure vs unstalled bins differing", bad, 0);
      rand_frame(0, 1'b1, 1'b1);
      bp[0] = 1'b0;
      bp[1] = 1'b1;
      rand_frame(1, 1'b0, 1'b1);
      rand_frame(1, 1'b1, 1'b1);
      bp[1] = 1'b0;
      @(posedge clk);
      #1;

      // Reset in the middle of COMPUTE, then a fresh impulse frame.
      for (int k = 0; k < 64; k++) begin xr[k] = (k == 0) ? 64 : 0; xi[k] = 0; end
      run_frame(0, xr, xi, 1'b0, 1'b0, 1'b0);
      repeat (4) begin @(posedge clk); #1; end
      @(negedge clk);
      check("pre-reset busy", int'(busy[0]), 1);
      rst[0] = 1'b1;
      @(posedge clk);
      #1;
      rst[0] = 1'b0;
      @(negedge clk);
      check("post-reset out_valid", int'(out_valid[0]), 0);
      check("post-reset busy", int'(busy[0]), 0);
      check("post-reset in_ready", int'(in_ready[0]), 1);
      @(posedge clk);
      #1;
      run_frame(0, xr, xi, 1'b0, 1'b0, 1'b1);
      wait_drain(0);
      check("post-reset impulse bin0", cap_r[0][0], 64);
      check("post-reset impulse bin7", cap_r[0][7], 64);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
